// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe -- execute stage with a one-entry EX/MEM output register.
//
// Sits between the ID/EX register and the memory stage. Single-cycle integer
// ops complete with latency 1 and stream at one op per cycle while the memory
// side keeps out_ready high. With EX_MUL_EN defined, opcode 24 runs an
// iterative shift-add multiplier (one multiplier bit per cycle). Without it,
// opcode 24 behaves as an undefined op (result 0) and busy is tied low.
//
// Configuration macro: EX_MUL_EN
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   flush               synchronous kill of in-flight and held work
//   in_valid/in_ready   ID-side handshake
//   in_op, in_a, in_b   opcode and operands
//   in_rd               destination register index
//   in_mem_read/write   load/store markers, passed through
//   out_valid/out_ready MEM-side handshake
//   out_result,out_zero registered result and (result == 0)
//   out_rd, out_mem_*   registered pass-through fields
//   busy                multiplier iterating
//
// state  | meaning
// -------+---------------------------------------------------------
// S_IDLE | accepting ops; single-cycle results written directly
// S_MUL  | multiplier iterating (EX_MUL_EN only), in_ready low
module ex_stage_pipe #(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_mem_read,
  input  logic            in_mem_write,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic [RD_W-1:0] out_rd,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            busy
);

  localparam int SHAMT_W = $clog2(XLEN);

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_SLL   = 5'd5;
  localparam logic [4:0] OP_SRL   = 5'd6;
  localparam logic [4:0] OP_SRA   = 5'd7;
  localparam logic [4:0] OP_SLT   = 5'd8;
  localparam logic [4:0] OP_SLTU  = 5'd9;
  localparam logic [4:0] OP_ADDI  = 5'd10;
  localparam logic [4:0] OP_XORI  = 5'd11;
  localparam logic [4:0] OP_ORI   = 5'd12;
  localparam logic [4:0] OP_ANDI  = 5'd13;
  localparam logic [4:0] OP_SLLI  = 5'd14;
  localparam logic [4:0] OP_SRLI  = 5'd15;
  localparam logic [4:0] OP_SRAI  = 5'd16;
  localparam logic [4:0] OP_SLTI  = 5'd17;
  localparam logic [4:0] OP_SLTIU = 5'd18;
  localparam logic [4:0] OP_PASSB = 5'd20;

`ifdef EX_MUL_EN
  localparam logic [4:0] OP_MUL = 5'd24;
  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic {S_IDLE, S_MUL} state_t;
`else
  typedef enum logic {S_IDLE} state_t;
`endif

  state_t state;

  logic [SHAMT_W-1:0] shamt;
  logic [XLEN-1:0]    alu_result;
  logic               accept;
  logic               is_mul;

  assign shamt = in_b[SHAMT_W-1:0];

  always_comb begin
    alu_result = '0;
    case (in_op)
      OP_ADD, OP_ADDI:   alu_result = in_a + in_b;
      OP_SUB:            alu_result = in_a - in_b;
      OP_AND, OP_ANDI:   alu_result = in_a & in_b;
      OP_OR, OP_ORI:     alu_result = in_a | in_b;
      OP_XOR, OP_XORI:   alu_result = in_a ^ in_b;
      OP_SLL, OP_SLLI:   alu_result = in_a << shamt;
      OP_SRL, OP_SRLI:   alu_result = in_a >> shamt;
      OP_SRA, OP_SRAI:   alu_result = $unsigned($signed(in_a) >>> shamt);
      OP_SLT, OP_SLTI:   alu_result = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SLTU, OP_SLTIU: alu_result = {{(XLEN-1){1'b0}}, (in_a < in_b)};
      OP_PASSB:          alu_result = in_b;
      default:           alu_result = '0;
    endcase
  end

  // Gating with rst keeps in_ready low for the whole time reset is held.
  assign in_ready = rst && (state == S_IDLE) && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

`ifdef EX_MUL_EN
  logic [XLEN-1:0]  mul_acc;
  logic [XLEN-1:0]  mul_mcand;
  logic [XLEN-1:0]  mul_mplier;
  logic [CNT_W-1:0] mul_cnt;
  logic [XLEN-1:0]  mul_step;

  assign is_mul   = (in_op == OP_MUL);
  assign mul_step = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
  assign busy     = (state == S_MUL);
`else
  assign is_mul = 1'b0;
  assign busy   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_zero      <= 1'b0;
      out_rd        <= '0;
      out_mem_read  <= 1'b0;
      out_mem_write <= 1'b0;
`ifdef EX_MUL_EN
      mul_acc       <= '0;
      mul_mcand     <= '0;
      mul_mplier    <= '0;
      mul_cnt       <= '0;
`endif
    end else if (flush) begin
      out_valid <= 1'b0;
      state     <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            // Pass-through fields are written at accept for both paths; the
            // register is free or freeing here, so nothing visible changes early.
            out_rd        <= in_rd;
            out_mem_read  <= in_mem_read;
            out_mem_write <= in_mem_write;
            if (is_mul) begin
              out_valid  <= 1'b0;
`ifdef EX_MUL_EN
              state      <= S_MUL;
              mul_acc    <= '0;
              mul_mcand  <= in_a;
              mul_mplier <= in_b;
              mul_cnt    <= CNT_W'(XLEN);
`endif
            end else begin
              out_valid  <= 1'b1;
              out_result <= alu_result;
              out_zero   <= (alu_result == '0);
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
`ifdef EX_MUL_EN
        S_MUL: begin
          if (mul_cnt == CNT_W'(1)) begin
            out_result <= mul_step;
            out_zero   <= (mul_step == '0);
            out_valid  <= 1'b1;
            state      <= S_IDLE;
          end else begin
            mul_acc    <= mul_step;
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
            mul_cnt    <= mul_cnt - CNT_W'(1);
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage_pipe.sv
module tb_ex_stage_pipe;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_rd;
  logic        in_mem_read;
  logic        in_mem_write;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic [4:0]  out_rd;
  logic        out_mem_read;
  logic        out_mem_write;
  logic        busy;

  ex_stage_pipe #(.XLEN(32), .RD_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_rd(out_rd),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .busy(busy)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        mr;
    logic        mw;
  } exp_t;

  exp_t sb[$];
  vec_t vq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   rdy_mode = 0;  // 0: out_ready=1, 1: out_ready=0, 2: random

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic issue(input vec_t v, input logic [4:0] rd, input logic mr, input logic mw);
    bit   ok;
    exp_t e;
    ok           = 1'b0;
    in_op        = v.op;
    in_a         = v.a;
    in_b         = v.b;
    in_rd        = rd;
    in_mem_read  = mr;
    in_mem_write = mw;
    in_valid     = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.res = v.res; e.rd = rd; e.mr = mr; e.mw = mw;
        sb.push_back(e);
        ok = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout op%0d: got no accept expected accept", v.op);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() > 0; i++) tick();
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every transfer on the MEM side pops one expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got result %h expected no output", out_result);
        end else begin
          e = sb.pop_front();
          check("result", out_result, e.res);
          check("zero", 32'(out_zero), 32'(e.res == 32'd0));
          check("rd", 32'(out_rd), 32'(e.rd));
          check("mem_flags", {30'd0, out_mem_read, out_mem_write}, {30'd0, e.mr, e.mw});
        end
      end
    end
  end

  initial begin
    int k;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_op = 5'd0; in_a = 32'd5; in_b = 32'd6; in_rd = 5'd3;
    in_mem_read = 1'b1; in_mem_write = 1'b1;

    // Reset held with an op presented.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_fields", {26'd0, out_zero, out_rd}, 32'd0);
    check("rst_mem_busy", {29'd0, out_mem_read, out_mem_write, busy}, 32'd0);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_release_in_ready", 32'(in_ready), 32'd1);
    tick();

    // ADD wrap to zero, latency 1.
    issue('{5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0}, 5'd1, 1'b0, 1'b0);
    check("add_lat1_valid", 32'(out_valid), 32'd1);
    check("add_lat1_result", out_result, 32'd0);
    check("add_lat1_zero", 32'(out_zero), 32'd1);

    // Directed vectors, back to back.
    vq.push_back('{5'd1,  32'd5,          32'd7,          32'hFFFF_FFFE});
    vq.push_back('{5'd7,  32'h8000_0000,  32'h24,         32'hF800_0000});
    vq.push_back('{5'd9,  32'd1,          32'hFFFF_FFFF,  32'd1});
    vq.push_back('{5'd8,  32'd1,          32'hFFFF_FFFF,  32'd0});
    vq.push_back('{5'd2,  32'hF0F0_00FF,  32'h0FF0_0F0F,  32'h00F0_000F});
    vq.push_back('{5'd3,  32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF});
    vq.push_back('{5'd4,  32'hA5A5_A5A5,  32'hFFFF_0000,  32'h5A5A_A5A5});
    vq.push_back('{5'd5,  32'd1,          32'd31,         32'h8000_0000});
    vq.push_back('{5'd6,  32'h8000_0000,  32'h3F,         32'd1});
    vq.push_back('{5'd10, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000});
    vq.push_back('{5'd11, 32'h0000_FFFF,  32'h00FF_00FF,  32'h00FF_FF00});
    vq.push_back('{5'd12, 32'h1234_0000,  32'h0000_5678,  32'h1234_5678});
    vq.push_back('{5'd13, 32'hFFFF_FFFF,  32'h0000_00F0,  32'h0000_00F0});
    vq.push_back('{5'd14, 32'd3,          32'd4,          32'h30});
    vq.push_back('{5'd15, 32'hF000_0000,  32'h1C,         32'hF});
    vq.push_back('{5'd16, 32'h4000_0000,  32'd2,          32'h1000_0000});
    vq.push_back('{5'd17, 32'hFFFF_FFFB,  32'd3,          32'd1});
    vq.push_back('{5'd18, 32'hFFFF_FFFB,  32'd3,          32'd0});
    vq.push_back('{5'd20, 32'h1111_1111,  32'hDEAD_BEEF,  32'hDEAD_BEEF});
    vq.push_back('{5'd19, 32'h1234_5678,  32'h1,          32'd0});
    k = 0;
    while (vq.size() > 0) begin
      issue(vq.pop_front(), 5'(k), k[0], k[1]);
      k++;
    end
    drain();

    // Backpressure: result held, input stalled.
    rdy_mode = 1; out_ready = 1'b0;
    issue('{5'd0, 32'd3, 32'd4, 32'd7}, 5'd9, 1'b1, 1'b0);
    tick(); tick();
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_hold_result", out_result, 32'd7);
    check("bp_hold_rd", 32'(out_rd), 32'd9);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    rdy_mode = 0; out_ready = 1'b1;
    issue('{5'd0, 32'd1, 32'd1, 32'd2}, 5'd10, 1'b0, 1'b1);
    drain();

    // Random stalls on the MEM side.
    rdy_mode = 2;
    vq.push_back('{5'd0,  32'd10,         32'd20,   32'd30});
    vq.push_back('{5'd1,  32'd100,        32'd1,    32'd99});
    vq.push_back('{5'd4,  32'hFF,         32'h0F,   32'hF0});
    vq.push_back('{5'd3,  32'd1,          32'd2,    32'd3});
    vq.push_back('{5'd2,  32'd6,          32'd3,    32'd2});
    vq.push_back('{5'd5,  32'd1,          32'd8,    32'h100});
    vq.push_back('{5'd6,  32'h100,        32'd4,    32'h10});
    vq.push_back('{5'd10, 32'hFFFF_FFF0,  32'h10,   32'd0});
    vq.push_back('{5'd20, 32'd0,          32'h55,   32'h55});
    vq.push_back('{5'd9,  32'd0,          32'd1,    32'd1});
    k = 0;
    while (vq.size() > 0) begin
      issue(vq.pop_front(), 5'(20 + k), k[1], k[0]);
      k++;
    end
    rdy_mode = 0;
    drain();

    // Flush with a held result and a presented op in the same cycle.
    rdy_mode = 1; out_ready = 1'b0;
    issue('{5'd0, 32'd2, 32'd2, 32'd4}, 5'd4, 1'b0, 1'b0);
    in_op = 5'd0; in_a = 32'd9; in_b = 32'd9; in_rd = 5'd5;
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    sb.delete();
    rdy_mode = 0;
    repeat (3) tick();
    check("flush_no_output", 32'(out_valid), 32'd0);

`ifdef EX_MUL_EN
    issue('{5'd24, 32'd1234, 32'd5678, 32'd7006652}, 5'd11, 1'b0, 1'b0);
    k = 1;
    while (!out_valid && k < 100) begin
      check("mul_busy", 32'(busy), 32'd1);
      tick();
      k++;
    end
    check("mul_latency", 32'(k), 32'd33);
    drain();
    issue('{5'd24, 32'd3, 32'd5, 32'd15}, 5'd12, 1'b0, 1'b0);
    repeat (9) tick();
    check("mul_busy_before_flush", 32'(busy), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("mul_flush_busy", 32'(busy), 32'd0);
    check("mul_flush_valid", 32'(out_valid), 32'd0);
    sb.delete();
    repeat (40) tick();
    check("mul_flush_no_output", 32'(out_valid), 32'd0);
`else
    issue('{5'd24, 32'd1234, 32'd5678, 32'd0}, 5'd11, 1'b1, 1'b0);
    check("op24_lat1_valid", 32'(out_valid), 32'd1);
    check("op24_result", out_result, 32'd0);
    check("op24_busy", 32'(busy), 32'd0);
    drain();
`endif

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
